// File: rtl/wb_scheduler_pkg.sv
// Shared constants and types for the writeback scheduler and its register-file side.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_MUL = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx
);

    localparam int SUM_W = PTR_W + 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [SUM_W-1:0] idx_sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_sum   = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Offset from the pointer, folded back into 0..NREQ-1.
            idx_sum = {1'b0, ptr_reg} + SUM_W'(k);
            if (idx_sum >= SUM_W'(NREQ)) begin
                idx_sum = idx_sum - SUM_W'(NREQ);
            end
            idx = idx_sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: round-robin sharing of the register-file write port plus
// a busy scoreboard of destinations with an in-flight producer.
module wb_scheduler #(
    parameter int NREQ = 3,
    parameter int XLEN = wb_pkg::XLEN,
    parameter int NREG = wb_pkg::NREG
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ*wb_pkg::REG_ADDR_W-1:0] req_addr,
    input  logic [NREQ*XLEN-1:0]            req_data,
    output logic [NREQ-1:0]                 req_ready,
    input  logic                            issue_valid,
    input  wb_pkg::reg_addr_t               issue_addr,
    output logic                            issue_ready,
    input  logic                            flush,
    input  wb_pkg::reg_addr_t               rs1_addr,
    input  wb_pkg::reg_addr_t               rs2_addr,
    output logic                            rs1_busy,
    output logic                            rs2_busy,
    output logic                            w_enabled,
    output wb_pkg::reg_addr_t               w_addr,
    output logic [XLEN-1:0]                 w_data
);

    localparam int AW    = wb_pkg::REG_ADDR_W;
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_pkg::reg_addr_t addr_arr [NREQ];
    logic [XLEN-1:0]   data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
        end
    endgenerate

    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              accept;
    wb_pkg::reg_addr_t sel_addr;
    logic [XLEN-1:0]   sel_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // No grant may be visible while reset is asserted.
    assign req_ready = grant & {NREQ{rstn}};
    assign accept    = |(req_valid & req_ready);
    assign sel_addr  = addr_arr[grant_idx];
    assign sel_data  = data_arr[grant_idx];

    // x0 results are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_enabled <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
        end else begin
            w_enabled <= accept && (sel_addr != '0);
            if (accept && (sel_addr != '0)) begin
                w_addr <= sel_addr;
                w_data <= sel_data;
            end
        end
    end

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic            claim;

    assign issue_ready = ~busy_reg[issue_addr] | (issue_addr == '0);
    assign claim       = issue_valid && issue_ready && (issue_addr != '0);

    // Order matters: a new claim overrides a retiring write, flush overrides both.
    always_comb begin
        busy_next = busy_reg;
        if (w_enabled) begin
            busy_next[w_addr] = 1'b0;
        end
        if (claim) begin
            busy_next[issue_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // The value being written this cycle reaches decode through the register-file bypass.
    assign rs1_busy = busy_reg[rs1_addr] & ~(w_enabled & (w_addr == rs1_addr)) & (rs1_addr != '0);
    assign rs2_busy = busy_reg[rs2_addr] & ~(w_enabled & (w_addr == rs2_addr)) & (rs2_addr != '0);

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed bench for wb_scheduler: a per-cycle vector table for arbitration and the
// write port, then hand-written scoreboard, flush and async-reset sequences.
module tb_wb_scheduler;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        w_enabled;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    int n_vec = 0;
    int n_bad = 0;

    wb_scheduler #(.NREQ(3), .XLEN(32), .NREG(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .flush       (flush),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .w_enabled   (w_enabled),
        .w_addr      (w_addr),
        .w_data      (w_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  mem_addr;
        logic [31:0] mem_data;
        logic [2:0]  exp_ready;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic [2:0] v,
                           input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1,
                           input logic [4:0] a2, input logic [31:0] d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Fixed ALU (x5=0x11) and MUL (x9=0x33); MEM varies per row. Pointer starts at 0.
        tbl[0]  = '{3'b011, 5'd6, 32'h22,       3'b001, 1'b0, 5'd0, 32'h0};
        tbl[1]  = '{3'b010, 5'd6, 32'h22,       3'b010, 1'b1, 5'd5, 32'h11};
        tbl[2]  = '{3'b000, 5'd6, 32'h22,       3'b000, 1'b1, 5'd6, 32'h22};
        tbl[3]  = '{3'b100, 5'd6, 32'h22,       3'b100, 1'b0, 5'd6, 32'h22};
        tbl[4]  = '{3'b111, 5'd6, 32'h22,       3'b001, 1'b1, 5'd9, 32'h33};
        tbl[5]  = '{3'b111, 5'd6, 32'h22,       3'b010, 1'b1, 5'd5, 32'h11};
        tbl[6]  = '{3'b111, 5'd6, 32'h22,       3'b100, 1'b1, 5'd6, 32'h22};
        tbl[7]  = '{3'b111, 5'd6, 32'h22,       3'b001, 1'b1, 5'd9, 32'h33};
        tbl[8]  = '{3'b111, 5'd6, 32'h22,       3'b010, 1'b1, 5'd5, 32'h11};
        tbl[9]  = '{3'b111, 5'd6, 32'h22,       3'b100, 1'b1, 5'd6, 32'h22};
        tbl[10] = '{3'b000, 5'd6, 32'h22,       3'b000, 1'b1, 5'd9, 32'h33};
        tbl[11] = '{3'b010, 5'd0, 32'hDEADBEEF, 3'b010, 1'b0, 5'd9, 32'h33};
        tbl[12] = '{3'b000, 5'd6, 32'h22,       3'b000, 1'b0, 5'd9, 32'h33};
        tbl[13] = '{3'b110, 5'd6, 32'h22,       3'b100, 1'b0, 5'd9, 32'h33};
        tbl[14] = '{3'b010, 5'd6, 32'h22,       3'b010, 1'b1, 5'd9, 32'h33};
        tbl[15] = '{3'b000, 5'd6, 32'h22,       3'b000, 1'b1, 5'd6, 32'h22};

        rstn        = 1'b0;
        issue_valid = 1'b0;
        issue_addr  = 5'd0;
        flush       = 1'b0;
        rs1_addr    = 5'd7;
        rs2_addr    = 5'd0;
        set_req(3'b111, 5'd5, 32'h11, 5'd6, 32'h22, 5'd9, 32'h33);

        // Reset held with every requester valid.
        repeat (3) next_cycle();
        #1;
        chk("rst_ready", 64'(req_ready), 64'(3'b000));
        chk("rst_wen", 64'(w_enabled), 64'(1'b0));
        chk("rst_waddr", 64'(w_addr), 64'(5'd0));
        chk("rst_wdata", 64'(w_data), 64'(32'h0));
        chk("rst_rs1_busy", 64'(rs1_busy), 64'(1'b0));
        rstn = 1'b1;
        #1;
        chk("rst_first_grant", 64'(req_ready), 64'(3'b001));
        req_valid = 3'b000;

        for (int i = 0; i < 16; i++) begin
            next_cycle();
            set_req(tbl[i].valid, 5'd5, 32'h11, tbl[i].mem_addr, tbl[i].mem_data, 5'd9, 32'h33);
            #1;
            $display("vec %0d: valid=%b ready=%b wen=%b waddr=%0d wdata=%h",
                     i, tbl[i].valid, req_ready, w_enabled, w_addr, w_data);
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(tbl[i].exp_ready));
            chk($sformatf("vec%0d_wen", i), 64'(w_enabled), 64'(tbl[i].exp_wen));
            chk($sformatf("vec%0d_waddr", i), 64'(w_addr), 64'(tbl[i].exp_waddr));
            chk($sformatf("vec%0d_wdata", i), 64'(w_data), 64'(tbl[i].exp_wdata));
        end

        // Claim x7.
        next_cycle();
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        chk("claim7_ready", 64'(issue_ready), 64'(1'b1));

        // x7 busy: WAW stall, RAW busy, x0 never busy; ALU delivers x7.
        next_cycle();
        rs1_addr = 5'd7; rs2_addr = 5'd0;
        set_req(3'b001, 5'd7, 32'h77, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        chk("waw7_stall", 64'(issue_ready), 64'(1'b0));
        chk("raw7_busy", 64'(rs1_busy), 64'(1'b1));
        chk("x0_not_busy", 64'(rs2_busy), 64'(1'b0));
        chk("alu7_grant", 64'(req_ready), 64'(3'b001));

        // Write cycle for x7 masks busy; ALU now delivers x8 (never claimed).
        next_cycle();
        issue_valid = 1'b0;
        set_req(3'b001, 5'd8, 32'h88, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        chk("w7_wen", 64'(w_enabled), 64'(1'b1));
        chk("w7_addr", 64'(w_addr), 64'(5'd7));
        chk("w7_data", 64'(w_data), 64'(32'h77));
        chk("w7_fwd_busy", 64'(rs1_busy), 64'(1'b0));

        // x8 written while claimed in the same cycle: the claim must win.
        next_cycle();
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        issue_valid = 1'b1; issue_addr = 5'd8;
        #1;
        chk("w8_wen", 64'(w_enabled), 64'(1'b1));
        chk("w8_addr", 64'(w_addr), 64'(5'd8));
        chk("claim8_ready", 64'(issue_ready), 64'(1'b1));

        next_cycle();
        issue_valid = 1'b0; issue_addr = 5'd7;
        rs1_addr = 5'd8; rs2_addr = 5'd7;
        #1;
        chk("set_wins_busy8", 64'(rs1_busy), 64'(1'b1));
        chk("x7_cleared", 64'(rs2_busy), 64'(1'b0));
        chk("x7_claimable", 64'(issue_ready), 64'(1'b1));

        // Claim x4, then flush alongside a claim of x9 and an accepted write to x4.
        next_cycle();
        issue_valid = 1'b1; issue_addr = 5'd4;
        #1;
        chk("claim4_ready", 64'(issue_ready), 64'(1'b1));

        next_cycle();
        flush = 1'b1;
        issue_valid = 1'b1; issue_addr = 5'd9;
        set_req(3'b001, 5'd4, 32'h44, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        chk("flush_grant", 64'(req_ready), 64'(3'b001));

        next_cycle();
        flush = 1'b0;
        issue_valid = 1'b0; issue_addr = 5'd4;
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        rs1_addr = 5'd8; rs2_addr = 5'd9;
        #1;
        chk("flush_w_wen", 64'(w_enabled), 64'(1'b1));
        chk("flush_w_addr", 64'(w_addr), 64'(5'd4));
        chk("flush_w_data", 64'(w_data), 64'(32'h44));
        chk("flush_busy8", 64'(rs1_busy), 64'(1'b0));
        chk("flush_beats_claim9", 64'(rs2_busy), 64'(1'b0));
        chk("flush_x4_free", 64'(issue_ready), 64'(1'b1));

        // Claim x3 and write x3 together; then assert reset mid write cycle.
        next_cycle();
        issue_valid = 1'b1; issue_addr = 5'd3;
        set_req(3'b001, 5'd3, 32'h33, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        chk("claim3_ready", 64'(issue_ready), 64'(1'b1));

        next_cycle();
        issue_valid = 1'b0; issue_addr = 5'd3;
        set_req(3'b001, 5'd10, 32'hAA, 5'd0, 32'h0, 5'd0, 32'h0);
        rs1_addr = 5'd3;
        #1;
        chk("pre_rst_wen", 64'(w_enabled), 64'(1'b1));
        chk("pre_rst_busy3", 64'(issue_ready), 64'(1'b0));
        chk("pre_rst_ready", 64'(req_ready), 64'(3'b001));
        #1;
        rstn = 1'b0;
        #1;
        chk("async_rst_wen", 64'(w_enabled), 64'(1'b0));
        chk("async_rst_waddr", 64'(w_addr), 64'(5'd0));
        chk("async_rst_busy3", 64'(issue_ready), 64'(1'b1));
        chk("async_rst_ready", 64'(req_ready), 64'(3'b000));
        chk("async_rst_rs1", 64'(rs1_busy), 64'(1'b0));
        set_req(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        rstn = 1'b1;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
